// File: rtl/conv_ifm_streamer_if.sv
// Pixel-stream bundle between the ifm streamer, the ifm/kernel buffers and the
// 1x1 conv MAC array. The streamer is the master.
interface conv_ifm_streamer_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16,
   parameter int CH_W   = 10,
   parameter int PIX_W  = 6
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic [CH_W-1:0]   ker_addr;
   logic [WIDTH-1:0]  pix_out;
   logic              pix_valid;
   logic              mac_clr;
   logic              acc_last;
   logic [PIX_W-1:0]  pix_idx;
   logic [CH_W-1:0]   ch_idx;

   modport master (
      output rd_en, rd_addr, ker_addr,
      output pix_out, pix_valid, mac_clr, acc_last, pix_idx, ch_idx,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, ker_addr,
      input  pix_out, pix_valid, mac_clr, acc_last, pix_idx, ch_idx,
      output rd_data
   );
endinterface

// File: rtl/conv_ifm_streamer.sv
// Walks every pixel x channel of an ifm buffer and streams one element per
// cycle to the broadcast input of a 1x1 conv MAC array, with clear/last strobes.
module conv_ifm_streamer #(
   parameter int WIDTH  = 16,
   parameter int CHIN   = 736,
   parameter int PIXELS = 64,
   parameter int ADDR_W = 16,
   parameter int CH_W   = 10,
   parameter int PIX_W  = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 pause,
   output logic                 busy,
   output logic                 done,
   conv_ifm_streamer_if.master  bus
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CHIN - 1);
   localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(PIXELS - 1);

   state_t            state, state_nxt;
   logic [CH_W-1:0]   ch;
   logic [PIX_W-1:0]  pix;
   logic [ADDR_W-1:0] addr;
   logic              issue;
   logic              ch_last;
   logic              pix_last;

   // output stage registers
   logic              vld_q;
   logic              clr_q;
   logic              last_q;
   logic [CH_W-1:0]   ch_q;
   logic [PIX_W-1:0]  pix_q;
   logic [WIDTH-1:0]  pix_hold;

   assign ch_last  = (ch == CH_MAX);
   assign pix_last = (pix == PIX_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = STREAM;
         end
         STREAM: begin
            issue = !pause;
            if (issue && ch_last && pix_last) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // rd_addr = pix*CHIN + ch advances by one per issue, so a running counter
   // replaces the multiply; all counters park at 0 after the final issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch   <= '0;
         pix  <= '0;
         addr <= '0;
      end else if (state == IDLE && start) begin
         ch   <= '0;
         pix  <= '0;
         addr <= '0;
      end else if (issue) begin
         if (ch_last) begin
            ch <= '0;
            if (pix_last) begin
               pix  <= '0;
               addr <= '0;
            end else begin
               pix  <= pix + PIX_W'(1);
               addr <= addr + ADDR_W'(1);
            end
         end else begin
            ch   <= ch + CH_W'(1);
            addr <= addr + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q    <= 1'b0;
         clr_q    <= 1'b0;
         last_q   <= 1'b0;
         ch_q     <= '0;
         pix_q    <= '0;
         pix_hold <= '0;
      end else begin
         vld_q  <= issue;
         clr_q  <= issue && (ch == '0);
         last_q <= issue && ch_last;
         if (issue) begin
            ch_q  <= ch;
            pix_q <= pix;
         end
         if (vld_q) pix_hold <= bus.rd_data;
      end
   end

   assign bus.rd_en     = issue;
   assign bus.rd_addr   = addr;
   assign bus.ker_addr  = ch;
   // buffer data lands exactly one cycle after the read; hold it between beats
   assign bus.pix_out   = vld_q ? bus.rd_data : pix_hold;
   assign bus.pix_valid = vld_q;
   assign bus.mac_clr   = clr_q;
   assign bus.acc_last  = last_q;
   assign bus.pix_idx   = pix_q;
   assign bus.ch_idx    = ch_q;

endmodule

// File: tb/tb_conv_ifm_streamer.sv
// Bench for conv_ifm_streamer: a 4ch x 2px instance for directed scenarios and a
// default-size instance for the full 47104-beat map.
module tb_conv_ifm_streamer;
   localparam int SCH = 4, SPX = 2, SAW = 16, SCW = 2, SPW = 1;
   localparam int DCH = 736, DPX = 64, DAW = 16, DCW = 10, DPW = 6;
   localparam int SN = SCH * SPX;
   localparam int DN = DCH * DPX;

   logic clk = 1'b0;
   logic rst;
   logic s_start, s_pause, s_busy, s_done;
   logic d_start, d_pause, d_busy, d_done;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_ifm_streamer_if #(.WIDTH(16), .ADDR_W(SAW), .CH_W(SCW), .PIX_W(SPW)) s_if ();
   conv_ifm_streamer_if #(.WIDTH(16), .ADDR_W(DAW), .CH_W(DCW), .PIX_W(DPW)) d_if ();

   conv_ifm_streamer #(.WIDTH(16), .CHIN(SCH), .PIXELS(SPX), .ADDR_W(SAW), .CH_W(SCW), .PIX_W(SPW))
      u_s (.clk(clk), .rst(rst), .start(s_start), .pause(s_pause), .busy(s_busy), .done(s_done), .bus(s_if.master));
   conv_ifm_streamer #(.WIDTH(16), .CHIN(DCH), .PIXELS(DPX), .ADDR_W(DAW), .CH_W(DCW), .PIX_W(DPW))
      u_d (.clk(clk), .rst(rst), .start(d_start), .pause(d_pause), .busy(d_busy), .done(d_done), .bus(d_if.master));

   // ifm buffers with 1-cycle read latency
   always @(posedge clk) if (s_if.rd_en) s_if.rd_data <= s_if.rd_addr + 16'd100;
   always @(posedge clk) if (d_if.rd_en) d_if.rd_data <= d_if.rd_addr ^ 16'h5a5a;

   typedef struct packed {
      logic [15:0]    d;
      logic           clr;
      logic           last;
      logic [SPW-1:0] p;
      logic [SCW-1:0] c;
   } beat_t;

   beat_t          exp_q[$];
   logic [SAW-1:0] addr_q[$];
   logic [15:0]    dexp_q[$];

   int tests = 0, fails = 0;
   int beats, rd_cnt, rd_first, v_first, v_last, done_cnt, done_cyc, gaps;
   int d_beats, d_rd, d_clr, d_last, d_wraps, d_bad, d_done_cyc, d_rd_last, d_prev_ker, d_next_addr;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic goto(int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic push_small();
      beat_t e;
      exp_q.delete();
      addr_q.delete();
      beats = 0; rd_cnt = 0; rd_first = -1; v_first = -1; v_last = -1;
      done_cnt = 0; done_cyc = -1; gaps = 0;
      for (int a = 0; a < SN; a++) begin
         addr_q.push_back(SAW'(a));
         e.d    = 16'(a + 100);
         e.clr  = (a % SCH == 0);
         e.last = (a % SCH == SCH - 1);
         e.p    = SPW'(a / SCH);
         e.c    = SCW'(a % SCH);
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_s_start(output int t);
      @(posedge clk); #1;
      s_start = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      s_start = 1'b0;
   endtask

   task automatic wait_s_done(int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
      check("s_done_seen", 64'(done_cnt), 64'(1));
   endtask

   // small-instance scoreboard monitor
   initial forever begin
      beat_t o;
      @(negedge clk);
      if (rst) begin
         if (s_if.rd_en) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = cyc;
            if (addr_q.size() == 0) check("rd_unexpected", 64'(addr_q.size()), 64'(1));
            else check("rd_addr", 64'(s_if.rd_addr), 64'(addr_q.pop_front()));
         end
         if (s_if.pix_valid) begin
            beats++;
            v_last = cyc;
            if (v_first < 0) v_first = cyc;
            o = '{d: s_if.pix_out, clr: s_if.mac_clr, last: s_if.acc_last, p: s_if.pix_idx, c: s_if.ch_idx};
            if (exp_q.size() == 0) check("beat_unexpected", 64'(exp_q.size()), 64'(1));
            else check("beat", 64'(o), 64'(exp_q.pop_front()));
         end else begin
            if (v_first >= 0 && beats < SN) gaps++;
            if (s_if.mac_clr || s_if.acc_last) check("strobe_gap", 64'({s_if.mac_clr, s_if.acc_last}), 64'(0));
         end
         if (s_done) begin done_cnt++; done_cyc = cyc; end
      end
   end

   // default-instance monitor: tallies, checked once at the end
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (d_if.rd_en) begin
            d_rd++;
            d_rd_last = int'(d_if.rd_addr);
            if (int'(d_if.rd_addr) != d_next_addr) d_bad++;
            d_next_addr++;
            if (d_prev_ker == DCH - 1 && d_if.ker_addr == '0) d_wraps++;
            d_prev_ker = int'(d_if.ker_addr);
         end
         if (d_if.pix_valid) begin
            d_beats++;
            if (d_if.mac_clr) d_clr++;
            if (d_if.acc_last) d_last++;
            if (dexp_q.size() == 0 || d_if.pix_out !== dexp_q.pop_front()) d_bad++;
         end
         if (d_done) d_done_cyc = cyc;
      end
   end

   initial begin
      int t, n;
      rst = 1'b0; s_start = 1'b1; s_pause = 1'b0; d_start = 1'b0; d_pause = 1'b0;
      d_beats = 0; d_rd = 0; d_clr = 0; d_last = 0; d_wraps = 0; d_bad = 0;
      d_done_cyc = -1; d_rd_last = -1; d_prev_ker = -1; d_next_addr = 0;
      push_small();

      // reset held with start high
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({s_if.rd_en, s_if.rd_addr, s_if.ker_addr, s_if.pix_out, s_if.pix_valid,
                                 s_if.mac_clr, s_if.acc_last, s_if.pix_idx, s_if.ch_idx, s_busy, s_done}), 64'(0));
      s_start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_no_reads", 64'(rd_cnt), 64'(0));
      check("idle_no_beats", 64'(beats), 64'(0));

      // plain run
      pulse_s_start(t);
      wait_s_done(40);
      check("first_rd_cycle", 64'(rd_first - t), 64'(1));
      check("first_beat_cycle", 64'(v_first - t), 64'(2));
      check("last_beat_cycle", 64'(v_last - t), 64'(1 + SN));
      check("done_cycle", 64'(done_cyc - t), 64'(2 + SN));
      check("busy_after_done", 64'(s_busy), 64'(0));
      check("beat_count", 64'(beats), 64'(SN));
      check("no_gaps", 64'(gaps), 64'(0));
      check("queue_drained", 64'(exp_q.size() + addr_q.size()), 64'(0));

      // pause for 3 cycles after the 2nd issue
      push_small();
      pulse_s_start(t);
      goto(t + 3);
      s_pause = 1'b1;
      goto(t + 6);
      s_pause = 1'b0;
      wait_s_done(40);
      check("pause_gaps", 64'(gaps), 64'(3));
      check("pause_beats", 64'(beats), 64'(SN));
      check("pause_reads", 64'(rd_cnt), 64'(SN));
      check("pause_done_cycle", 64'(done_cyc - t), 64'(2 + SN + 3));
      check("pause_queue_drained", 64'(exp_q.size() + addr_q.size()), 64'(0));

      // start while busy and in the DONE cycle
      push_small();
      pulse_s_start(t);
      goto(t + 3);
      s_start = 1'b1;
      goto(t + 4);
      s_start = 1'b0;
      goto(t + 2 + SN);
      check("done_cycle_busy", 64'({s_done, s_busy}), 64'(3));
      s_start = 1'b1;
      goto(t + 3 + SN);
      s_start = 1'b0;
      goto(t + 20 + SN);
      check("busy_start_reads", 64'(rd_cnt), 64'(SN));
      check("busy_start_beats", 64'(beats), 64'(SN));
      check("busy_start_done_cnt", 64'(done_cnt), 64'(1));
      check("busy_start_idle", 64'(s_busy), 64'(0));

      // reset at beat 5
      push_small();
      pulse_s_start(t);
      n = 0;
      while (beats < 5 && n < 40) begin @(posedge clk); #1; n++; end
      check("beat5_reached", 64'(beats), 64'(5));
      #2 rst = 1'b0;
      #1;
      check("async_reset_outputs", 64'({s_if.rd_en, s_if.rd_addr, s_if.ker_addr, s_if.pix_out, s_if.pix_valid,
                                       s_if.mac_clr, s_if.acc_last, s_if.pix_idx, s_if.ch_idx, s_busy, s_done}), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      push_small();
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt), 64'(0));
      check("abort_no_reads", 64'(rd_cnt), 64'(0));
      pulse_s_start(t);
      wait_s_done(40);
      check("rerun_first_rd", 64'(rd_first - t), 64'(1));
      check("rerun_beats", 64'(beats), 64'(SN));
      check("rerun_queue_drained", 64'(exp_q.size() + addr_q.size()), 64'(0));

      // full default-size map
      for (int a = 0; a < DN; a++) dexp_q.push_back(16'(a) ^ 16'h5a5a);
      @(posedge clk); #1;
      d_start = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      d_start = 1'b0;
      n = 0;
      while (d_done_cyc < 0 && n < DN + 100) begin @(posedge clk); #1; n++; end
      check("d_done_cycle", 64'(d_done_cyc - t), 64'(DN + 2));
      check("d_beats", 64'(d_beats), 64'(DN));
      check("d_reads", 64'(d_rd), 64'(DN));
      check("d_last_addr", 64'(d_rd_last), 64'(DN - 1));
      check("d_acc_last_cnt", 64'(d_last), 64'(DPX));
      check("d_mac_clr_cnt", 64'(d_clr), 64'(DPX));
      check("d_ker_wraps", 64'(d_wraps), 64'(DPX - 1));
      check("d_data_addr_errs", 64'(d_bad), 64'(0));
      check("d_busy_after", 64'(d_busy), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
